// File: rtl/step_pulse_gen.sv
// step_pulse_gen: turns the divided slow clock and the KEY0 push button into
// single-cycle step strobes in the clk_in domain for the baccarat dealer.
// Optional auto path: define STEP_PULSE_GEN_AUTO_EN to step on slow_clk edges
// while auto_mode is set. Without it, slow_clk and auto_mode are ignored.
//
// Debounce FSM
//   state          | meaning
//   S_IDLE         | button released and stable
//   S_PRESS_WAIT   | press seen, counting stable low cycles
//   S_PRESSED      | press accepted, one step issued
//   S_RELEASE_WAIT | release seen, counting stable high cycles
module step_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       slow_clk,
  input  logic       key_n,
  input  logic       auto_mode,
  output logic       step,
  output logic [3:0] step_count,
  output logic       key_held
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_PRESS_WAIT   = 2'd1,
    S_PRESSED      = 2'd2,
    S_RELEASE_WAIT = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_db_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   r_man_edge;
  logic                   w_man_edge_nxt;
  logic [SYNC_STAGES-1:0] r_key_sync;
  logic                   w_key_sync;
  logic                   w_step_nxt;
  logic                   r_step;
  logic [3:0]             r_step_count;

  // Button synchronizer; resets to released (1) so reset never looks like a press
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) r_key_sync <= '1;
    else     r_key_sync <= {r_key_sync[SYNC_STAGES-2:0], key_n};
  end

  assign w_key_sync = r_key_sync[SYNC_STAGES-1];

  // Debounce state, counter and registered manual edge
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_db_cnt   <= '0;
      r_man_edge <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_db_cnt   <= w_cnt_nxt;
      r_man_edge <= w_man_edge_nxt;
    end
  end

  // Debounce next-state logic; only the press acceptance produces a step
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_db_cnt;
    w_man_edge_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_key_sync) begin
          w_state_nxt = S_PRESS_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      S_PRESS_WAIT: begin
        if (w_key_sync) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_db_cnt == CNT_LAST) begin
          w_state_nxt    = S_PRESSED;
          w_man_edge_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_db_cnt + CNT_W'(1);
        end
      end
      S_PRESSED: begin
        if (w_key_sync) begin
          w_state_nxt = S_RELEASE_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      S_RELEASE_WAIT: begin
        if (!w_key_sync) begin
          w_state_nxt = S_PRESSED;
        end else if (r_db_cnt == CNT_LAST) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_db_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Held indication covers the release debounce window as well
  always_comb begin
    key_held = (r_state == S_PRESSED) || (r_state == S_RELEASE_WAIT);
  end

`ifdef STEP_PULSE_GEN_AUTO_EN
  logic [SYNC_STAGES-1:0] r_slow_sync;
  logic [SYNC_STAGES-1:0] r_auto_sync;
  logic                   w_slow_sync;
  logic                   w_auto_sync;
  logic                   r_slow_prev;
  logic                   w_auto_edge;
  logic                   r_auto_edge;

  // Synchronize the slow clock and the mode switch
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_slow_sync <= '0;
      r_auto_sync <= '0;
    end else begin
      r_slow_sync <= {r_slow_sync[SYNC_STAGES-2:0], slow_clk};
      r_auto_sync <= {r_auto_sync[SYNC_STAGES-2:0], auto_mode};
    end
  end

  assign w_slow_sync = r_slow_sync[SYNC_STAGES-1];
  assign w_auto_sync = r_auto_sync[SYNC_STAGES-1];
  assign w_auto_edge = w_slow_sync & ~r_slow_prev;

  // Rising-edge detect runs regardless of mode, so flipping auto_mode cannot create an edge
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_slow_prev <= 1'b0;
      r_auto_edge <= 1'b0;
    end else begin
      r_slow_prev <= w_slow_sync;
      r_auto_edge <= w_auto_edge;
    end
  end

  assign w_step_nxt = r_man_edge | (w_auto_sync & r_auto_edge);
`else
  logic w_unused_inputs;
  assign w_unused_inputs = slow_clk ^ auto_mode;
  assign w_step_nxt      = r_man_edge;
`endif

  // Merged strobe: coincident manual and auto events give a single step
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) r_step <= 1'b0;
    else     r_step <= w_step_nxt;
  end

  // Step counter, wraps modulo 16
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst)         r_step_count <= 4'd0;
    else if (r_step) r_step_count <= r_step_count + 4'd1;
  end

  assign step       = r_step;
  assign step_count = r_step_count;

endmodule
